// File: rtl/riscv_defines.sv
// Shared definitions for the core-side memory arbiter.
//   RISCV_ADDR_WIDTH : address width of fetch, LSU and memory buses
//   arb_state_e      : arbiter phase (IDLE / REQ_HOLD / WAIT_RESP)
//   arb_owner_e      : which requester currently owns the memory port
package riscv_defines;

    localparam int RISCV_ADDR_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ_HOLD  = 2'd1,
        WAIT_RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        INSTR = 1'b0,
        DATA  = 1'b1
    } arb_owner_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch unit, the LSU, the arbiter and the memory.
//   instr_* : fetch request / grant / response
//   data_*  : LSU request / grant / response
//   mem_*   : shared single-outstanding memory port
// Modports:
//   slave  : the arbiter side (takes requests, drives grants and memory request)
//   master : the environment side (requesters plus memory)
interface mem_arbiter_if #(
    parameter int DATA_WIDTH = 32
) ();
    import riscv_defines::*;

    logic                        instr_req_i;
    logic [RISCV_ADDR_WIDTH-1:0] instr_addr_i;
    logic                        instr_gnt_o;
    logic                        instr_rvalid_o;
    logic [DATA_WIDTH-1:0]       instr_rdata_o;

    logic                        data_req_i;
    logic                        data_we_i;
    logic [DATA_WIDTH/8-1:0]     data_be_i;
    logic [RISCV_ADDR_WIDTH-1:0] data_addr_i;
    logic [DATA_WIDTH-1:0]       data_wdata_i;
    logic                        data_gnt_o;
    logic                        data_rvalid_o;
    logic [DATA_WIDTH-1:0]       data_rdata_o;

    logic                        mem_req_o;
    logic                        mem_we_o;
    logic [DATA_WIDTH/8-1:0]     mem_be_o;
    logic [RISCV_ADDR_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0]       mem_wdata_o;
    logic                        mem_gnt_i;
    logic                        mem_rvalid_i;
    logic [DATA_WIDTH-1:0]       mem_rdata_i;

    modport slave (
        input  instr_req_i, instr_addr_i,
        output instr_gnt_o, instr_rvalid_o, instr_rdata_o,
        input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        output data_gnt_o, data_rvalid_o, data_rdata_o,
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );

    modport master (
        output instr_req_i, instr_addr_i,
        input  instr_gnt_o, instr_rvalid_o, instr_rdata_o,
        output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        input  data_gnt_o, data_rvalid_o, data_rdata_o,
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );

endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (fetch / LSU) arbiter onto one memory port with at most one
// transaction outstanding. Requests are forwarded in the same cycle they are
// seen; once a request is presented but not granted, its owner is locked
// until the grant. When both requesters compete, the LSU wins unless it was
// the last one granted, so fetches cannot be starved.
// Ports:
//   clk   : clock, all state on posedge
//   rst_n : asynchronous active-low reset
//   bus   : mem_arbiter_if.slave (fetch, LSU and memory signals)
module mem_arbiter #(
    parameter int DATA_WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);
    import riscv_defines::*;

    localparam int BE_WIDTH = DATA_WIDTH / 8;

    arb_state_e state_q, state_d;
    arb_owner_e owner_q, owner_d;
    arb_owner_e last_q,  last_d;
    arb_owner_e pick;
    arb_owner_e cur_owner;
    logic       any_req;
    logic       issue;
    logic       granted;
    logic       resp;

    // Fresh arbitration, only consulted in IDLE.
    always_comb begin
        any_req = bus.instr_req_i | bus.data_req_i;
        if (bus.data_req_i && !(bus.instr_req_i && last_q == DATA)) begin
            pick = DATA;
        end else begin
            pick = INSTR;
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        issue     = 1'b0;
        granted   = 1'b0;
        cur_owner = owner_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    issue     = 1'b1;
                    cur_owner = pick;
                    owner_d   = pick;
                    if (bus.mem_gnt_i) begin
                        granted = 1'b1;
                        last_d  = pick;
                        state_d = WAIT_RESP;
                    end else begin
                        state_d = REQ_HOLD;
                    end
                end
            end
            REQ_HOLD: begin
                issue = 1'b1;
                if (bus.mem_gnt_i) begin
                    granted = 1'b1;
                    last_d  = owner_q;
                    state_d = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                if (bus.mem_rvalid_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Outputs are forced quiet for the whole time reset is held.
        if (!rst_n) begin
            issue   = 1'b0;
            granted = 1'b0;
        end
    end

    assign resp = rst_n && (state_q == WAIT_RESP) && bus.mem_rvalid_i;

    always_comb begin
        bus.mem_req_o      = issue;
        bus.mem_we_o       = 1'b0;
        bus.mem_be_o       = '0;
        bus.mem_addr_o     = '0;
        bus.mem_wdata_o    = '0;
        if (issue) begin
            if (cur_owner == DATA) begin
                bus.mem_we_o    = bus.data_we_i;
                bus.mem_be_o    = bus.data_be_i;
                bus.mem_addr_o  = bus.data_addr_i;
                bus.mem_wdata_o = bus.data_wdata_i;
            end else begin
                // Fetches are always full-word reads.
                bus.mem_be_o    = {BE_WIDTH{1'b1}};
                bus.mem_addr_o  = bus.instr_addr_i;
            end
        end
        bus.instr_gnt_o    = granted && (cur_owner == INSTR);
        bus.data_gnt_o     = granted && (cur_owner == DATA);
        bus.instr_rvalid_o = resp && (owner_q == INSTR);
        bus.data_rvalid_o  = resp && (owner_q == DATA);
        bus.instr_rdata_o  = bus.mem_rdata_i;
        bus.data_rdata_o   = bus.mem_rdata_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= INSTR;
            last_q  <= INSTR;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a per-cycle vector table, directed
// corner sequences (held write with competing fetch, reset mid-transaction),
// then randomized traffic checked against a transaction-level model.
module tb_mem_arbiter;
    import riscv_defines::*;

    localparam int DW = 32;

    typedef logic [137:0] obs_t;

    typedef struct {
        logic        ir;
        logic [31:0] ia;
        logic        dr;
        logic        dwe;
        logic [3:0]  dbe;
        logic [31:0] da;
        logic [31:0] dwd;
        logic        g;
        logic        rv;
        logic [31:0] rd;
        logic        er;
        logic        ewe;
        logic [3:0]  ebe;
        logic [31:0] ea;
        logic [31:0] ewd;
        logic        eig;
        logic        eir;
        logic        edg;
        logic        edr;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    mem_arbiter_if #(.DATA_WIDTH(DW)) bus ();

    mem_arbiter #(.DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t row(
        logic ir, logic [31:0] ia, logic dr, logic dwe, logic [3:0] dbe,
        logic [31:0] da, logic [31:0] dwd, logic g, logic rv, logic [31:0] rd,
        logic er, logic ewe, logic [3:0] ebe, logic [31:0] ea, logic [31:0] ewd,
        logic eig, logic eir, logic edg, logic edr);
        vec_t v;
        v.ir = ir;  v.ia = ia;  v.dr = dr;  v.dwe = dwe; v.dbe = dbe;
        v.da = da;  v.dwd = dwd; v.g = g;   v.rv = rv;   v.rd = rd;
        v.er = er;  v.ewe = ewe; v.ebe = ebe; v.ea = ea; v.ewd = ewd;
        v.eig = eig; v.eir = eir; v.edg = edg; v.edr = edr;
        return v;
    endfunction

    function automatic obs_t sample();
        return {bus.mem_req_o, bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o,
                bus.mem_wdata_o, bus.instr_gnt_o, bus.instr_rvalid_o,
                bus.data_gnt_o, bus.data_rvalid_o, bus.instr_rdata_o,
                bus.data_rdata_o};
    endfunction

    function automatic obs_t expect_of(vec_t v);
        return {v.er, v.ewe, v.ebe, v.ea, v.ewd, v.eig, v.eir, v.edg, v.edr,
                v.rd, v.rd};
    endfunction

    task automatic drive(vec_t v);
        bus.instr_req_i  = v.ir;
        bus.instr_addr_i = v.ia;
        bus.data_req_i   = v.dr;
        bus.data_we_i    = v.dwe;
        bus.data_be_i    = v.dbe;
        bus.data_addr_i  = v.da;
        bus.data_wdata_i = v.dwd;
        bus.mem_gnt_i    = v.g;
        bus.mem_rvalid_i = v.rv;
        bus.mem_rdata_i  = v.rd;
    endtask

    task automatic check(string name, obs_t act, obs_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("[TB] ok   %s %h", name, act);
        end
    endtask

    // One cycle: drive on the falling edge, compare 1 ns later.
    task automatic apply(string name, vec_t v);
        @(negedge clk);
        drive(v);
        #1;
        check(name, sample(), expect_of(v));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive(row(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    vec_t tbl[$];

    // Random-phase state
    logic        i_act, d_act, d_we;
    logic [31:0] i_addr, d_addr, d_wd;
    logic [3:0]  d_be;
    // Reference model: a transaction is either being offered (held) or
    // accepted and awaiting its response (out); last_data remembers who won.
    bit m_out, m_out_data, m_held, m_held_data, m_last_data;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        drive(row(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Lone fetch, alternation over 6 transactions, spurious rvalid, lock in hold.
        tbl.push_back(row(1,'h100,0,0,0,0,0, 1,0,0,              1,0,'hF,'h100,0, 1,0,0,0));
        tbl.push_back(row(0,0,0,0,0,0,0,     0,0,0,              0,0,0,0,0,       0,0,0,0));
        tbl.push_back(row(0,0,0,0,0,0,0,     0,1,'h13,           0,0,0,0,0,       0,1,0,0));
        tbl.push_back(row(1,'h104,1,0,'hF,'h300,'h55, 1,0,0,     1,0,'hF,'h300,'h55, 0,0,1,0));
        tbl.push_back(row(1,'h104,0,0,0,0,0, 0,0,0,              0,0,0,0,0,       0,0,0,0));
        tbl.push_back(row(1,'h104,0,0,0,0,0, 0,1,'hAAAA0001,     0,0,0,0,0,       0,0,0,1));
        tbl.push_back(row(1,'h104,1,1,'h5,'h304,'h1234, 1,0,0,   1,0,'hF,'h104,0, 1,0,0,0));
        tbl.push_back(row(0,0,1,1,'h5,'h304,'h1234, 0,1,'hBAD,   0,0,0,0,0,       0,1,0,0));
        tbl.push_back(row(1,'h108,1,1,'h5,'h304,'h1234, 1,0,0,   1,1,'h5,'h304,'h1234, 0,0,1,0));
        tbl.push_back(row(1,'h108,0,0,0,0,0, 0,1,'h77,           0,0,0,0,0,       0,0,0,1));
        tbl.push_back(row(1,'h108,1,0,'hC,'h308,0, 1,0,0,        1,0,'hF,'h108,0, 1,0,0,0));
        tbl.push_back(row(0,0,1,0,'hC,'h308,0, 0,1,'h88,         0,0,0,0,0,       0,1,0,0));
        tbl.push_back(row(1,'h10C,1,0,'hC,'h308,0, 1,0,0,        1,0,'hC,'h308,0, 0,0,1,0));
        tbl.push_back(row(1,'h10C,0,0,0,0,0, 0,1,'h99,           0,0,0,0,0,       0,0,0,1));
        tbl.push_back(row(1,'h10C,1,0,'h3,'h30C,0, 1,0,0,        1,0,'hF,'h10C,0, 1,0,0,0));
        tbl.push_back(row(0,0,1,0,'h3,'h30C,0, 0,1,'h66,         0,0,0,0,0,       0,1,0,0));
        tbl.push_back(row(0,0,1,0,'h3,'h30C,0, 1,0,0,            1,0,'h3,'h30C,0, 0,0,1,0));
        tbl.push_back(row(0,0,0,0,0,0,0,     0,1,'h44,           0,0,0,0,0,       0,0,0,1));
        tbl.push_back(row(0,0,0,0,0,0,0,     0,1,'hDEAD,         0,0,0,0,0,       0,0,0,0));
        tbl.push_back(row(1,'h110,0,0,0,0,0, 0,0,0,              1,0,'hF,'h110,0, 0,0,0,0));
        tbl.push_back(row(1,'h110,1,1,'hF,'h400,'hFF, 0,1,'h1,   1,0,'hF,'h110,0, 0,0,0,0));
        tbl.push_back(row(1,'h110,1,1,'hF,'h400,'hFF, 1,0,0,     1,0,'hF,'h110,0, 1,0,0,0));
        tbl.push_back(row(0,0,1,1,'hF,'h400,'hFF, 0,1,'h2,       0,0,0,0,0,       0,1,0,0));
        tbl.push_back(row(0,0,1,1,'hF,'h400,'hFF, 1,0,0,         1,1,'hF,'h400,'hFF, 0,0,1,0));
        tbl.push_back(row(0,0,0,0,0,0,0,     0,1,'h3,            0,0,0,0,0,       0,0,0,1));

        foreach (tbl[i]) apply($sformatf("table[%0d]", i), tbl[i]);

        // Write held for three cycles while a fetch arrives: owner stays LSU.
        apply("hold_w0", row(0,0,1,1,'h3,'h200,'hCAFEBABE, 0,0,0, 1,1,'h3,'h200,'hCAFEBABE, 0,0,0,0));
        apply("hold_w1", row(1,'h120,1,1,'h3,'h200,'hCAFEBABE, 0,0,0, 1,1,'h3,'h200,'hCAFEBABE, 0,0,0,0));
        apply("hold_w2", row(1,'h120,1,1,'h3,'h200,'hCAFEBABE, 0,0,0, 1,1,'h3,'h200,'hCAFEBABE, 0,0,0,0));
        apply("hold_gnt", row(1,'h120,1,1,'h3,'h200,'hCAFEBABE, 1,0,0, 1,1,'h3,'h200,'hCAFEBABE, 0,0,1,0));
        apply("hold_wait", row(1,'h120,0,0,0,0,0, 0,0,0, 0,0,0,0,0, 0,0,0,0));
        apply("hold_resp", row(1,'h120,0,0,0,0,0, 0,1,'h5, 0,0,0,0,0, 0,0,0,1));
        apply("fetch_next", row(1,'h120,0,0,0,0,0, 1,0,0, 1,0,'hF,'h120,0, 1,0,0,0));
        apply("fetch_resp", row(0,0,0,0,0,0,0, 0,1,'h6, 0,0,0,0,0, 0,1,0,0));

        // Reset while waiting for a response; the late response is dropped.
        apply("rst_fetch", row(1,'h140,0,0,0,0,0, 1,0,0, 1,0,'hF,'h140,0, 1,0,0,0));
        @(negedge clk);
        rst_n = 1'b0;
        drive(row(1,'h144,0,0,0,0,0, 1,1,'h7, 0,0,0,0,0,0,0,0,0));
        #1;
        check("in_reset", sample(), expect_of(row(0,0,0,0,0,0,0,0,0,'h7, 0,0,0,0,0,0,0,0,0)));
        #2;
        drive(row(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        apply("late_resp", row(0,0,0,0,0,0,0, 0,1,'hBEEF, 0,0,0,0,0, 0,0,0,0));
        apply("post_fetch", row(1,'h144,0,0,0,0,0, 1,0,0, 1,0,'hF,'h144,0, 1,0,0,0));
        apply("post_resp", row(0,0,0,0,0,0,0, 0,1,'h13, 0,0,0,0,0, 0,1,0,0));

        // Randomized traffic against the transaction-level model.
        do_reset();
        m_out = 0; m_out_data = 0; m_held = 0; m_held_data = 0; m_last_data = 0;
        i_act = 0; d_act = 0; i_addr = 0; d_addr = 0; d_wd = 0; d_be = 0; d_we = 0;
        for (int c = 0; c < 2000; c++) begin
            vec_t v;
            bit own_data;
            @(negedge clk);
            if (!i_act && ($urandom_range(0, 2) == 0)) begin
                i_act  = 1;
                i_addr = {$urandom_range(0, 'hFFFF), 2'b00};
            end
            if (!d_act && ($urandom_range(0, 2) == 0)) begin
                d_act  = 1;
                d_we   = 1'($urandom_range(0, 1));
                d_be   = 4'($urandom_range(1, 15));
                d_addr = $urandom;
                d_wd   = $urandom;
            end
            v = row(i_act, i_addr, d_act, d_we, d_be, d_addr, d_wd,
                    1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), $urandom,
                    0,0,0,0,0, 0,0,0,0);
            if (m_out) begin
                if (v.rv) begin
                    if (m_out_data) v.edr = 1; else v.eir = 1;
                end
            end else if (m_held || i_act || d_act) begin
                own_data = m_held ? m_held_data : (d_act && !(i_act && m_last_data));
                v.er = 1;
                if (own_data) begin
                    v.ewe = d_we; v.ebe = d_be; v.ea = d_addr; v.ewd = d_wd;
                end else begin
                    v.ebe = 4'hF; v.ea = i_addr;
                end
                if (v.g) begin
                    if (own_data) v.edg = 1; else v.eig = 1;
                end
            end
            drive(v);
            #1;
            check($sformatf("rand[%0d]", c), sample(), expect_of(v));
            // Advance the model to the state after the coming clock edge.
            if (m_out) begin
                if (v.rv) m_out = 0;
            end else if (v.er) begin
                own_data = v.edg || (!v.eig && (m_held ? m_held_data
                                     : (d_act && !(i_act && m_last_data))));
                if (v.g) begin
                    m_out       = 1;
                    m_out_data  = own_data;
                    m_last_data = own_data;
                    m_held      = 0;
                end else begin
                    m_held      = 1;
                    m_held_data = own_data;
                end
            end
            if (v.eig) i_act = 0;
            if (v.edg) d_act = 0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, memory data width in bits.
REQ-002 clk  in  1  single clock; all state updates on posedge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 instr_req_i  in  1  fetch request; held with address until instr_gnt_o.
REQ-005 instr_addr_i  in  RISCV_ADDR_WIDTH  fetch address.
REQ-006 instr_gnt_o  out  1  fetch request accepted by memory.
REQ-007 instr_rvalid_o  out  1  fetch read data valid, one cycle.
REQ-008 instr_rdata_o  out  DATA_WIDTH  fetch read data.
REQ-009 data_req_i  in  1  LSU request; held with all attributes until data_gnt_o.
REQ-010 data_we_i  in  1  LSU write enable.
REQ-011 data_be_i  in  DATA_WIDTH/8  LSU byte enables.
REQ-012 data_addr_i  in  RISCV_ADDR_WIDTH  LSU address.
REQ-013 data_wdata_i  in  DATA_WIDTH  LSU write data.
REQ-014 data_gnt_o  out  1  LSU request accepted.
REQ-015 data_rvalid_o  out  1  LSU response valid (reads and writes), one cycle.
REQ-016 data_rdata_o  out  DATA_WIDTH  LSU read data.
REQ-017 mem_req_o / mem_we_o / mem_be_o / mem_addr_o / mem_wdata_o  out  1/1/DATA_WIDTH/8/RISCV_ADDR_WIDTH/DATA_WIDTH  shared memory request.
REQ-018 mem_gnt_i / mem_rvalid_i / mem_rdata_i  in  1/1/DATA_WIDTH  memory grant, response valid, read data.

Function
REQ-019 SHALL implement states IDLE, REQ_HOLD, WAIT_RESP and a registered owner (INSTR/DATA); at most one transaction outstanding.
REQ-020 IDLE: if any request pending, SHALL pick owner combinationally and drive mem_req_o=1 with that owner's address/we/be/wdata in the same cycle (zero-cycle request latency).
REQ-021 Selection: only one requester -> it; both -> DATA, unless last granted owner was DATA, then INSTR (alternation prevents fetch starvation).
REQ-022 Instruction requests SHALL drive mem_we_o=0, mem_be_o all ones, mem_wdata_o=0.
REQ-023 IDLE with mem_gnt_i=1: assert owner's gnt combinationally same cycle, latch owner, next state WAIT_RESP.
REQ-024 IDLE with request but mem_gnt_i=0: latch owner, next state REQ_HOLD.
REQ-025 REQ_HOLD: owner locked; mem_req_o=1 with locked owner's signals; other requester SHALL NOT switch in; on mem_gnt_i -> owner gnt, WAIT_RESP.
REQ-026 WAIT_RESP: mem_req_o=0, both gnt outputs 0; on mem_rvalid_i, owner's rvalid=1 same cycle, next state IDLE; new request arbitrated no earlier than following cycle.
REQ-027 instr_rdata_o and data_rdata_o SHALL both equal mem_rdata_i; only the owner's rvalid asserts.
REQ-028 mem_rvalid_i in IDLE or REQ_HOLD SHALL be ignored (no rvalid output); mem_gnt_i while mem_req_o=0 ignored.
REQ-029 Last-granted-owner register updates only on a grant; reset value INSTR.
REQ-030 Non-owner gnt/rvalid outputs SHALL be 0 in every cycle.

Reset
REQ-031 On rst_n low: state IDLE, owner INSTR, last-granted INSTR; all outputs combinationally 0 except pass-through rdata; an outstanding transaction is abandoned and its late mem_rvalid_i dropped per REQ-028.

Structure
REQ-032 State enum and owner enum SHALL be added to riscv_defines package alongside RISCV_ADDR_WIDTH; no sub-modules.

Verification
REQ-033 Lone fetch 0x100, mem_gnt_i same cycle, rvalid 2 cycles later rdata 0x00000013 -> instr_gnt_o cycle 0, instr_rvalid_o cycle 2 with 0x13, data_* outputs 0.
REQ-034 Both request in IDLE, reset history -> DATA granted first (last=INSTR); then both again -> INSTR granted; strict alternation over 6 transactions.
REQ-035 Data write 0x200 be=0b0011, mem_gnt_i delayed 3 cycles, instr_req_i raised mid-wait -> mem_addr_o stays 0x200, mem_we_o=1 until grant; fetch served next.
REQ-036 Spurious mem_rvalid_i in IDLE -> no rvalid output, state unchanged.
REQ-037 rst_n pulsed low in WAIT_RESP, then mem_rvalid_i -> dropped; next fetch completes normally.
